// File: rtl/mips_exec_core.sv
// mips_exec_core: execute/write-back stage of a two-stage MIPS datapath.
// Decodes the instruction in EX, reads a 32x32 register file with write-through
// bypass, runs a 32-bit ALU with a HI/LO multiply pair, and registers the
// result for write-back one cycle later. GPIO is reached through mtc0/mfc0.
module mips_exec_core (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic [31:0] gpio_in,
    output logic [31:0] gpio_out
);

    typedef enum logic [3:0] {
        ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_ADD, ALU_SUB, ALU_MULT,
        ALU_MULTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_LUI
    } alu_op_t;

    // B operand sources
    localparam logic [1:0] B_RT   = 2'd0;
    localparam logic [1:0] B_SEXT = 2'd1;
    localparam logic [1:0] B_ZEXT = 2'd2;

    // write-back data sources
    localparam logic [1:0] WD_ALU  = 2'd0;
    localparam logic [1:0] WD_HI   = 2'd1;
    localparam logic [1:0] WD_LO   = 2'd2;
    localparam logic [1:0] WD_GPIO = 2'd3;

    // instruction fields
    logic [5:0]  w_op, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
    logic [15:0] w_imm;

    assign w_op    = instr[31:26];
    assign w_rs    = instr[25:21];
    assign w_rt    = instr[20:16];
    assign w_rd    = instr[15:11];
    assign w_shamt = instr[10:6];
    assign w_funct = instr[5:0];
    assign w_imm   = instr[15:0];

    // architectural state
    logic [31:0] r_rf [32];
    logic [31:0] r_hi, r_lo;
    logic        r_wb_we;
    logic [4:0]  r_wb_addr;
    logic [31:0] r_wb_data;

    // decode outputs
    alu_op_t     w_alu_op;
    logic [1:0]  w_bsel, w_wsel;
    logic        w_we, w_hilo_we, w_gpio_we;
    logic [4:0]  w_dst;

    // datapath
    logic [31:0] w_a, w_rtv, w_b, w_alu_res, w_wdata;
    logic [63:0] w_sprod, w_uprod, w_prod;
    logic        w_alu_zero_unused;

    // Decode: anything not listed leaves w_we/w_hilo_we/w_gpio_we low (NOP)
    always_comb begin
        w_alu_op  = ALU_ADD;
        w_bsel    = B_RT;
        w_wsel    = WD_ALU;
        w_we      = 1'b0;
        w_hilo_we = 1'b0;
        w_gpio_we = 1'b0;
        w_dst     = w_rt;
        case (w_op)
            6'h00: begin
                w_dst = w_rd;
                w_we  = 1'b1;
                case (w_funct)
                    6'h20, 6'h21: w_alu_op = ALU_ADD;
                    6'h22, 6'h23: w_alu_op = ALU_SUB;
                    6'h24: w_alu_op = ALU_AND;
                    6'h25: w_alu_op = ALU_OR;
                    6'h26: w_alu_op = ALU_XOR;
                    6'h27: w_alu_op = ALU_NOR;
                    6'h2A: w_alu_op = ALU_SLT;
                    6'h2B: w_alu_op = ALU_SLTU;
                    6'h00: w_alu_op = ALU_SLL;
                    6'h02: w_alu_op = ALU_SRL;
                    6'h03: w_alu_op = ALU_SRA;
                    6'h10: w_wsel = WD_HI;
                    6'h12: w_wsel = WD_LO;
                    6'h18: begin w_alu_op = ALU_MULT;  w_we = 1'b0; w_hilo_we = 1'b1; end
                    6'h19: begin w_alu_op = ALU_MULTU; w_we = 1'b0; w_hilo_we = 1'b1; end
                    default: w_we = 1'b0;
                endcase
            end
            6'h08, 6'h09: begin w_alu_op = ALU_ADD;  w_bsel = B_SEXT; w_we = 1'b1; end
            6'h0A:        begin w_alu_op = ALU_SLT;  w_bsel = B_SEXT; w_we = 1'b1; end
            6'h0B:        begin w_alu_op = ALU_SLTU; w_bsel = B_SEXT; w_we = 1'b1; end
            6'h0C:        begin w_alu_op = ALU_AND;  w_bsel = B_ZEXT; w_we = 1'b1; end
            6'h0D:        begin w_alu_op = ALU_OR;   w_bsel = B_ZEXT; w_we = 1'b1; end
            6'h0E:        begin w_alu_op = ALU_XOR;  w_bsel = B_ZEXT; w_we = 1'b1; end
            6'h0F:        begin w_alu_op = ALU_LUI;  w_bsel = B_ZEXT; w_we = 1'b1; end
            6'h10: begin
                if (w_rs == 5'h04) begin
                    w_gpio_we = 1'b1;
                end else if (w_rs == 5'h00) begin
                    w_wsel = WD_GPIO;
                    w_we   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Read ports: $0 is hard zero; a pending write-back to the same address wins
    assign w_a   = (w_rs == 5'd0) ? 32'd0 :
                   (r_wb_we && r_wb_addr == w_rs) ? r_wb_data : r_rf[w_rs];
    assign w_rtv = (w_rt == 5'd0) ? 32'd0 :
                   (r_wb_we && r_wb_addr == w_rt) ? r_wb_data : r_rf[w_rt];

    // B operand mux
    always_comb begin
        case (w_bsel)
            B_SEXT:  w_b = {{16{w_imm[15]}}, w_imm};
            B_ZEXT:  w_b = {16'h0, w_imm};
            default: w_b = w_rtv;
        endcase
    end

    assign w_sprod = $signed({{32{w_a[31]}}, w_a}) * $signed({{32{w_b[31]}}, w_b});
    assign w_uprod = {32'h0, w_a} * {32'h0, w_b};

    // ALU: shifts operate on B (rt) by shamt; multiplies also expose the full product
    always_comb begin
        w_alu_res = 32'd0;
        w_prod    = 64'd0;
        case (w_alu_op)
            ALU_AND:   w_alu_res = w_a & w_b;
            ALU_OR:    w_alu_res = w_a | w_b;
            ALU_XOR:   w_alu_res = w_a ^ w_b;
            ALU_NOR:   w_alu_res = ~(w_a | w_b);
            ALU_ADD:   w_alu_res = w_a + w_b;
            ALU_SUB:   w_alu_res = w_a - w_b;
            ALU_MULT:  begin w_prod = w_sprod; w_alu_res = w_sprod[31:0]; end
            ALU_MULTU: begin w_prod = w_uprod; w_alu_res = w_uprod[31:0]; end
            ALU_SLL:   w_alu_res = w_b << w_shamt;
            ALU_SRL:   w_alu_res = w_b >> w_shamt;
            ALU_SRA:   w_alu_res = $signed(w_b) >>> w_shamt;
            ALU_SLT:   w_alu_res = {31'd0, $signed(w_a) < $signed(w_b)};
            ALU_SLTU:  w_alu_res = {31'd0, w_a < w_b};
            ALU_LUI:   w_alu_res = {w_b[15:0], 16'h0};
            default:   w_alu_res = 32'd0;
        endcase
    end

    // zero flag is produced for completeness; no control path consumes it
    assign w_alu_zero_unused = (w_alu_res == 32'd0);

    // Write-back data select
    always_comb begin
        case (w_wsel)
            WD_HI:   w_wdata = r_hi;
            WD_LO:   w_wdata = r_lo;
            WD_GPIO: w_wdata = gpio_in;
            default: w_wdata = w_alu_res;
        endcase
    end

    // EX->WB pipeline registers; reset drops any in-flight write-back
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_we   <= 1'b0;
            r_wb_addr <= 5'd0;
            r_wb_data <= 32'd0;
        end else begin
            r_wb_we   <= w_we;
            r_wb_addr <= w_dst;
            r_wb_data <= w_wdata;
        end
    end

    // Register file write port; writes to $0 are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) r_rf[i] <= 32'd0;
        end else if (r_wb_we && r_wb_addr != 5'd0) begin
            r_rf[r_wb_addr] <= r_wb_data;
        end
    end

    // HI/LO update at the end of the multiply's EX cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_hilo_we) begin
            r_hi <= w_prod[63:32];
            r_lo <= w_prod[31:0];
        end
    end

    // GPIO output register loaded by mtc0
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            gpio_out <= 32'd0;
        else if (w_gpio_we) gpio_out <= w_rtv;
    end

endmodule

// File: tb/tb_mips_exec_core.sv
// Directed bench for mips_exec_core: register values are observed by moving
// them to gpio_out with mtc0 and comparing against hand-computed results.
module tb_mips_exec_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic [31:0] gpio_in;
    logic [31:0] gpio_out;

    int n_cmp = 0;
    int n_bad = 0;

    mips_exec_core dut (
        .clk      (clk),
        .rst      (rst),
        .instr    (instr),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] r_t(input logic [5:0] fn, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] sh);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_t(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] mtc0(input logic [4:0] rt);
        return {6'h10, 5'h04, rt, 16'h0};
    endfunction

    function automatic logic [31:0] mfc0(input logic [4:0] rt);
        return {6'h10, 5'h00, rt, 16'h0};
    endfunction

    // present one instruction for one full cycle; returns at the next negedge
    task automatic ex(input logic [31:0] i);
        instr = i;
        @(negedge clk);
    endtask

    // move register r to gpio_out and check it
    task automatic see(input string tag, input logic [4:0] r, input logic [31:0] exp);
        ex(mtc0(r));
        chk(tag, gpio_out, exp);
    endtask

    initial begin
        rst     = 1'b1;
        instr   = 32'h0;
        gpio_in = 32'h0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_gpio", gpio_out, 32'h0);
        rst = 1'b0;

        // back-to-back dependency through the bypass
        ex(i_t(6'h09, 5'd0, 5'd1, 16'd5));          // addiu $1,$0,5
        ex(i_t(6'h09, 5'd1, 5'd2, 16'hFFF9));       // addiu $2,$1,-7
        see("bypass_chain", 5'd2, 32'hFFFFFFFE);
        see("addiu_r1", 5'd1, 32'h5);

        // logic ops
        ex(i_t(6'h0F, 5'd0, 5'd3, 16'h1234));       // lui
        ex(i_t(6'h0D, 5'd3, 5'd3, 16'hF0F0));       // ori
        see("lui_ori", 5'd3, 32'h1234F0F0);
        ex(i_t(6'h0E, 5'd3, 5'd9, 16'hFFFF));       // xori
        see("xori", 5'd9, 32'h12340F0F);
        ex(i_t(6'h0C, 5'd3, 5'd4, 16'h8000));       // andi
        see("andi_zext", 5'd4, 32'h00008000);

        // shifts and compares
        ex(i_t(6'h0F, 5'd0, 5'd5, 16'h8000));       // $5 = 0x80000000
        ex(r_t(6'h03, 5'd0, 5'd5, 5'd6, 5'd4));     // sra
        see("sra", 5'd6, 32'hF8000000);
        ex(r_t(6'h02, 5'd0, 5'd5, 5'd6, 5'd4));     // srl
        see("srl", 5'd6, 32'h08000000);
        ex(r_t(6'h2A, 5'd5, 5'd0, 5'd7, 5'd0));     // slt
        see("slt", 5'd7, 32'h1);
        ex(r_t(6'h2B, 5'd5, 5'd0, 5'd7, 5'd0));     // sltu
        see("sltu", 5'd7, 32'h0);

        // assorted arithmetic
        ex(r_t(6'h22, 5'd1, 5'd2, 5'd10, 5'd0));    // sub 5-(-2)
        see("sub", 5'd10, 32'h7);
        ex(r_t(6'h27, 5'd0, 5'd0, 5'd10, 5'd0));    // nor
        see("nor", 5'd10, 32'hFFFFFFFF);
        ex(r_t(6'h00, 5'd0, 5'd1, 5'd10, 5'd3));    // sll 5<<3
        see("sll", 5'd10, 32'h28);
        ex(i_t(6'h0A, 5'd2, 5'd10, 16'h0));         // slti -2<0
        see("slti", 5'd10, 32'h1);
        ex(i_t(6'h0B, 5'd2, 5'd10, 16'h1));         // sltiu FFFFFFFE<1
        see("sltiu_lo", 5'd10, 32'h0);
        ex(i_t(6'h0B, 5'd2, 5'd10, 16'hFFFF));      // sltiu FFFFFFFE<FFFFFFFF
        see("sltiu_sext", 5'd10, 32'h1);

        // signed multiply
        ex(i_t(6'h09, 5'd0, 5'd11, 16'hFFFD));      // -3
        ex(i_t(6'h09, 5'd0, 5'd12, 16'd7));
        ex(r_t(6'h18, 5'd11, 5'd12, 5'd0, 5'd0));   // mult
        ex(r_t(6'h10, 5'd0, 5'd0, 5'd13, 5'd0));    // mfhi right after mult
        see("mult_hi", 5'd13, 32'hFFFFFFFF);
        ex(r_t(6'h12, 5'd0, 5'd0, 5'd13, 5'd0));    // mflo
        see("mult_lo", 5'd13, 32'hFFFFFFEB);

        // unsigned multiply
        ex(i_t(6'h09, 5'd0, 5'd14, 16'hFFFF));      // 0xFFFFFFFF
        ex(i_t(6'h09, 5'd0, 5'd15, 16'd2));
        ex(r_t(6'h19, 5'd14, 5'd15, 5'd0, 5'd0));   // multu
        ex(r_t(6'h10, 5'd0, 5'd0, 5'd13, 5'd0));
        see("multu_hi", 5'd13, 32'h1);
        ex(r_t(6'h12, 5'd0, 5'd0, 5'd13, 5'd0));
        see("multu_lo", 5'd13, 32'hFFFFFFFE);

        // unsupported encodings must not touch rf or HI/LO
        ex(i_t(6'h23, 5'd0, 5'd13, 16'h1234));      // lw (unsupported)
        ex(r_t(6'h01, 5'd0, 5'd0, 5'd13, 5'd0));    // bad funct
        see("unsup_nop", 5'd13, 32'hFFFFFFFE);
        ex(r_t(6'h10, 5'd0, 5'd0, 5'd13, 5'd0));
        see("unsup_hi", 5'd13, 32'h1);

        // GPIO input path
        gpio_in = 32'hA5A50001;
        ex(mfc0(5'd8));
        gpio_in = 32'h0;
        see("mfc0", 5'd8, 32'hA5A50001);

        // $0 stays zero even with a pending write to it
        ex(i_t(6'h09, 5'd0, 5'd0, 16'h0055));
        see("r0_write", 5'd0, 32'h0);

        // reset mid-run with a write-back in flight
        ex(i_t(6'h09, 5'd0, 5'd1, 16'h0077));
        see("pre_reset", 5'd1, 32'h77);
        ex(i_t(6'h09, 5'd0, 5'd1, 16'h0099));       // write to $1 now pending
        instr = 32'h0;
        #1 rst = 1'b1;
        #1 chk("reset_async", gpio_out, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        see("reset_r1", 5'd1, 32'h0);
        see("reset_r3", 5'd3, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_exec_core.md
# mips_exec_core

Execute/write-back core of the two-stage MIPS datapath. It decodes the instruction currently in EX, reads a 32×32 register file, computes in a 32-bit ALU with a HI/LO multiply pair, and writes results back one cycle later. It also provides a 32-bit GPIO port through coprocessor-0 move instructions. Instruction fetch and the PC are outside this block; one instruction enters on `instr` each cycle.

## Interface
No parameters.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `instr`  in  32  instruction in EX; 0x00000000 is a NOP (`sll $0,$0,0`)
- `gpio_in`  in  32  sampled by `mfc0`
- `gpio_out`  out  32  registered; loaded by `mtc0`

## Operation
- **Fields.** op=`[31:26]`, rs=`[25:21]`, rt=`[20:16]`, rd=`[15:11]`, shamt=`[10:6]`, funct=`[5:0]`, imm=`[15:0]`.
- **Register file.**
  - 32×32 entries.
  - Two combinational read ports, addressed by rs (operand A) and rt.
  - One synchronous write port.
  - `$0` always reads 0, and writes to it are discarded.
  - If a read address equals the address being written that cycle, the read returns the write data (write-through bypass).
- **R-type (op=0x00)**, all write rd:
  - add 0x20 and addu 0x21: a+b. No overflow trap.
  - sub 0x22 and subu 0x23: a−b.
  - and 0x24, or 0x25, xor 0x26, nor 0x27.
  - slt 0x2A: signed compare, result 1 or 0. sltu 0x2B: unsigned compare.
  - sll 0x00, srl 0x02, sra 0x03: shift rt by shamt.
  - mfhi 0x10 and mflo 0x12: rd←HI or rd←LO.
  - mult 0x18 (signed) and multu 0x19 (unsigned): {HI,LO}←rs×rt. No register write.
- **I-type**, all write rt, B=imm:
  - addi 0x08, addiu 0x09, slti 0x0A, sltiu 0x0B: sign-extended immediate.
  - andi 0x0C, ori 0x0D, xori 0x0E: zero-extended immediate.
  - lui 0x0F: rt←{imm,16'h0}.
- **GPIO (op=0x10).**
  - rs=0x04 (mtc0): `gpio_out`←rt value. No register write.
  - rs=0x00 (mfc0): rt←`gpio_in`.
- **Unsupported encodings** behave as NOP: no register, HI/LO or GPIO update.
- **ALU.**
  - 4-bit op selects: AND, OR, XOR, NOR, ADD, SUB, MULT, MULTU, SLL, SRL, SRA, SLT, SLTU, LUI.
  - B mux: rt value, sign-extended imm, or zero-extended imm.
  - Arithmetic is modulo 2^32. SRA replicates bit 31.
  - `zero` = (result==0). It is computed internally and not used for control.
- **HI/LO.** Registers written only by mult/multu, at the end of that instruction's EX cycle.

## Timing
- **Cycle n (EX):** decode, register read and ALU are combinational. At the closing edge the block captures into WB registers:
  - regwrite
  - destination address (rd or rt)
  - write data (ALU result, HI, LO or `gpio_in`)
- **HI/LO and `gpio_out`** also update at the closing edge of cycle n.
- **Cycle n+1 (WB):** the register file is written at the closing edge. The bypass makes the value visible to the instruction in EX during cycle n+1, so back-to-back dependencies need no stall.
- **Dependencies on multiply results:** mfhi/mflo directly after mult returns the new product. mtc0 directly after a producer sends the bypassed value.
- **Reset** (asynchronous, any time):
  - all 32 registers, HI, LO and `gpio_out` clear to 0;
  - WB regwrite clears to 0;
  - an in-flight write-back is discarded.
- **Throughput:** one instruction per cycle. No stalls or handshakes.

## Test plan
- Reset mid-run: assert `rst` after writing $1 → `gpio_out`=0 immediately; mtc0 of $1 then outputs 0.
- `addiu $1,$0,5` → `addiu $2,$1,-7` → `mtc0 $2` → `gpio_out`=0xFFFFFFFE with no gap instructions (bypass).
- Logic ops:
  - `lui $3,0x1234`; `ori $3,$3,0xF0F0` → $3=0x1234F0F0.
  - `xori` with 0xFFFF → 0x12340F0F.
  - `andi $4,$3,0x8000` → 0x00008000, confirming zero extension.
- Shifts and compares, with $5=0x80000000:
  - `sra $6,$5,4` → 0xF8000000.
  - `srl` → 0x08000000.
  - `slt $7,$5,$0` → 1.
  - `sltu $7,$5,$0` → 0.
- Multiply:
  - `mult` of −3 and 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
  - `multu` of 0xFFFFFFFF and 2 → HI=1, LO=0xFFFFFFFE.
  - Check each via mfhi/mflo→mtc0.
- `mfc0 $8` with `gpio_in`=0xA5A5_0001, then `mtc0 $8` → `gpio_out`=0xA5A50001. Also write to $0 then mtc0 $0 → 0.
